// File: rtl/dip_axis_pkg.sv
// Shared types for the DIP AXI4-Stream front-end blocks.
package dip_axis_pkg;

  // Border generator sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TOP    = 3'd1,
    ST_LEFT   = 3'd2,
    ST_DATA   = 3'd3,
    ST_RIGHT  = 3'd4,
    ST_BOTTOM = 3'd5
  } bgen_state_e;

  // Output tuser bit positions.
  localparam int TU_SOF    = 0;
  localparam int TU_BORDER = 1;
  localparam int TU_EOF    = 2;
  localparam int TUSER_W   = 3;

endpackage

// File: rtl/axis_img_border_gen_ext_if.sv
// AXI4-Stream beat bundle with source (master) and sink (slave) views.
interface axis_img_border_gen_ext_if #(
  parameter int DATA_W = 16,
  parameter int USER_W = 1
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [USER_W-1:0] tuser;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_img_border_gen_ext.sv
// Wraps each input frame in a BORDER_W-wide border on all four sides.
// Data beats pass through combinationally; border beats come from config
// or from the row's edge pixels. x/y count output columns/rows.
module axis_img_border_gen_ext
  import dip_axis_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int IMG_RES_X = 336,
  parameter int IMG_RES_Y = 256,
  parameter int BORDER_W  = 1,
  parameter int CNT_W     = 16
) (
  input  logic                      axis_aclk,
  input  logic                      axis_areset,
  input  logic [DATA_W-1:0]         cfg_border_val,
  input  logic                      cfg_h_replicate,
  axis_img_border_gen_ext_if.slave  s_axis,
  axis_img_border_gen_ext_if.master m_axis,
  output logic                      err_sof,
  output logic                      err_tlast
);

  localparam int OX = IMG_RES_X + 2 * BORDER_W;
  localparam int OY = IMG_RES_Y + 2 * BORDER_W;

  localparam logic [CNT_W-1:0] X_LAST    = CNT_W'(OX - 1);
  localparam logic [CNT_W-1:0] Y_LAST    = CNT_W'(OY - 1);
  localparam logic [CNT_W-1:0] X_L_END   = CNT_W'(BORDER_W - 1);
  localparam logic [CNT_W-1:0] Y_T_END   = CNT_W'(BORDER_W - 1);
  localparam logic [CNT_W-1:0] X_D_FIRST = CNT_W'(BORDER_W);
  localparam logic [CNT_W-1:0] Y_D_FIRST = CNT_W'(BORDER_W);
  localparam logic [CNT_W-1:0] X_D_END   = CNT_W'(BORDER_W + IMG_RES_X - 1);
  localparam logic [CNT_W-1:0] Y_D_END   = CNT_W'(BORDER_W + IMG_RES_Y - 1);

  bgen_state_e        state_q, state_d;
  logic [CNT_W-1:0]   x_q, x_d, y_q, y_d;
  logic [DATA_W-1:0]  hold_q, border_q;
  logic               rep_q;
  logic               err_sof_q, err_tlast_q;

  logic               m_vld, m_lst, s_rdy;
  logic [DATA_W-1:0]  m_dat;
  logic [TUSER_W-1:0] m_usr;
  logic               fire, d_fire, row_end, sof_seen;

  assign fire     = m_vld & m_axis.tready;
  assign d_fire   = fire & (state_q == ST_DATA);
  assign row_end  = (x_q == X_LAST);
  assign sof_seen = (state_q == ST_IDLE) & s_axis.tvalid & s_axis.tuser[0];

  // State and position registers.
  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // Sequencing: walk output raster one transferred beat at a time.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    if (state_q == ST_IDLE) begin
      if (sof_seen) begin
        state_d = ST_TOP;
        x_d     = '0;
        y_d     = '0;
      end
    end else if (fire) begin
      x_d = row_end ? '0 : x_q + CNT_W'(1);
      if (row_end) y_d = y_q + CNT_W'(1);
      case (state_q)
        ST_TOP:    if (row_end && y_q == Y_T_END) state_d = ST_LEFT;
        ST_LEFT:   if (x_q == X_L_END) state_d = ST_DATA;
        ST_DATA:   if (x_q == X_D_END) state_d = ST_RIGHT;
        ST_RIGHT:  if (row_end) state_d = (y_q == Y_D_END) ? ST_BOTTOM : ST_LEFT;
        ST_BOTTOM: if (row_end && y_q == Y_LAST) begin
                     state_d = ST_IDLE;
                     y_d     = '0;
                   end
        default:   ;
      endcase
    end
  end

  // Beat sourcing per state; everything held at zero while in reset.
  always_comb begin
    m_vld = 1'b0;
    m_dat = '0;
    m_usr = '0;
    m_lst = 1'b0;
    s_rdy = 1'b0;
    if (!axis_areset) begin
      case (state_q)
        // Drop junk, but leave the SOF beat waiting so it becomes pixel 0.
        ST_IDLE:   s_rdy = ~s_axis.tuser[0];
        ST_TOP,
        ST_BOTTOM: begin
          m_vld = 1'b1;
          m_dat = border_q;
        end
        // Replicate mode peeks at the pending first pixel without taking it.
        ST_LEFT: begin
          m_vld = rep_q ? s_axis.tvalid : 1'b1;
          m_dat = rep_q ? s_axis.tdata  : border_q;
        end
        ST_DATA: begin
          m_vld = s_axis.tvalid;
          m_dat = s_axis.tdata;
          s_rdy = m_axis.tready;
        end
        ST_RIGHT: begin
          m_vld = 1'b1;
          m_dat = rep_q ? hold_q : border_q;
        end
        default: ;
      endcase
      if (state_q != ST_IDLE) begin
        m_lst            = row_end;
        m_usr[TU_SOF]    = (x_q == '0) && (y_q == '0);
        m_usr[TU_BORDER] = (state_q != ST_DATA);
        m_usr[TU_EOF]    = row_end && (y_q == Y_LAST);
      end
    end
  end

  // Frame config latch, edge-pixel hold and framing-error pulses.
  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      hold_q      <= '0;
      border_q    <= '0;
      rep_q       <= 1'b0;
      err_sof_q   <= 1'b0;
      err_tlast_q <= 1'b0;
    end else begin
      err_sof_q   <= 1'b0;
      err_tlast_q <= 1'b0;
      if (sof_seen) begin
        border_q <= cfg_border_val;
        rep_q    <= cfg_h_replicate;
      end
      if (d_fire) begin
        hold_q      <= s_axis.tdata;
        err_tlast_q <= s_axis.tlast != (x_q == X_D_END);
        err_sof_q   <= s_axis.tuser[0] && !((x_q == X_D_FIRST) && (y_q == Y_D_FIRST));
      end
    end
  end

  assign m_axis.tvalid = m_vld;
  assign m_axis.tdata  = m_dat;
  assign m_axis.tuser  = m_usr;
  assign m_axis.tlast  = m_lst;
  assign s_axis.tready = s_rdy;
  assign err_sof       = err_sof_q;
  assign err_tlast     = err_tlast_q;

endmodule

// File: tb/tb_axis_img_border_gen_ext.sv
// Directed bench: 4x3 image, BORDER_W=2 -> 8x7 output frame.
module tb_axis_img_border_gen_ext;

  logic        clk = 1'b0;
  logic        areset;
  logic [15:0] cfg_border_val;
  logic        cfg_h_replicate;
  logic        err_sof, err_tlast;
  int          ntests = 0;
  int          nfail  = 0;

  axis_img_border_gen_ext_if #(.DATA_W(16), .USER_W(1)) s_if ();
  axis_img_border_gen_ext_if #(.DATA_W(16), .USER_W(3)) m_if ();

  axis_img_border_gen_ext #(
    .DATA_W(16), .IMG_RES_X(4), .IMG_RES_Y(3), .BORDER_W(2), .CNT_W(16)
  ) dut (
    .axis_aclk      (clk),
    .axis_areset    (areset),
    .cfg_border_val (cfg_border_val),
    .cfg_h_replicate(cfg_h_replicate),
    .s_axis         (s_if),
    .m_axis         (m_if),
    .err_sof        (err_sof),
    .err_tlast      (err_tlast)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hand-derived picture: rows 2..4 / cols 2..5 hold pixels 1..12.
  function automatic logic [15:0] exp_pix(input bit rep, input int x, input int y);
    int r;
    if (y < 2 || y > 4) return 16'hABCD;
    r = y - 2;
    if (x >= 2 && x <= 5) return 16'(r * 4 + x - 1);
    if (!rep) return 16'hABCD;
    return (x < 2) ? 16'(r * 4 + 1) : 16'(r * 4 + 4);
  endfunction

  task automatic run_frame(input bit rep, input bit gaps, input bit rnd, input bit junk,
                           input bit errm, input int abort_at);
    logic [17:0] inq[$];
    logic [19:0] prev, cur, expv;
    int idx = 0, k = 0, cyc = 0, ntl = 0, nsf = 0, x, y;
    bit held = 1'b0, prev_stall = 1'b0, lst, usr;
    if (junk) begin
      inq.push_back({2'b00, 16'hDEAD});
      inq.push_back({2'b00, 16'hBEEF});
    end
    for (int p = 0; p < 12; p++) begin
      lst = (p % 4 == 3);
      if (errm && p == 2) lst = 1'b1;
      if (errm && p == 3) lst = 1'b0;
      usr = (p == 0) || (errm && p == 5);
      inq.push_back({usr, lst, 16'(p + 1)});
    end
    cfg_border_val  = 16'hABCD;
    cfg_h_replicate = rep;
    while (k < 56 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (k > 0) begin
        cfg_border_val  = 16'h5555;
        cfg_h_replicate = !rep;
      end
      if (abort_at >= 0 && k == abort_at) begin
        areset = 1'b1;
        #1;
        chk("reset_mid_outputs",
            {m_if.tvalid, m_if.tuser, m_if.tlast, s_if.tready, err_sof, err_tlast}, 0);
        @(negedge clk);
        areset      = 1'b0;
        s_if.tvalid = 1'b0;
        return;
      end
      if (!held) begin
        if (idx < inq.size() && !(gaps && $urandom_range(0, 2) == 0)) begin
          s_if.tvalid = 1'b1;
          {s_if.tuser, s_if.tlast, s_if.tdata} = inq[idx];
        end else begin
          s_if.tvalid = 1'b0;
        end
      end
      m_if.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      cur = {m_if.tvalid, m_if.tdata, m_if.tuser};
      if (prev_stall) chk("stall_stable", {cur, m_if.tlast}, {prev, 1'b0} | {20'd0, 1'b0});
      if (m_if.tvalid && m_if.tready) begin
        x = k % 8;
        y = k / 8;
        expv = {1'b1, exp_pix(rep, x, y), (k == 55),
                !(y >= 2 && y <= 4 && x >= 2 && x <= 5), (k == 0)};
        chk($sformatf("beat%0d", k), {cur, m_if.tlast}, {expv, x == 7});
        k++;
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev       = cur;
      if (prev_stall && m_if.tlast) prev_stall = 1'b0;
      if (s_if.tvalid && s_if.tready) begin
        idx++;
        held = 1'b0;
      end else begin
        held = s_if.tvalid;
      end
      ntl += int'(err_tlast);
      nsf += int'(err_sof);
    end
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      ntl += int'(err_tlast);
      nsf += int'(err_sof);
    end
    chk("frame_beats", k, 56);
    chk("err_tlast_cnt", ntl, errm ? 2 : 0);
    chk("err_sof_cnt", nsf, errm ? 1 : 0);
    chk("idle_after_frame", {m_if.tvalid, s_if.tready}, 2'b01);
  endtask

  initial begin
    areset          = 1'b1;
    cfg_border_val  = 16'hABCD;
    cfg_h_replicate = 1'b0;
    s_if.tvalid     = 1'b0;
    s_if.tdata      = '0;
    s_if.tlast      = 1'b0;
    s_if.tuser      = '0;
    m_if.tready     = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs",
        {m_if.tvalid, m_if.tuser, m_if.tlast, s_if.tready, err_sof, err_tlast}, 0);
    @(negedge clk);
    areset = 1'b0;
    #1;
    chk("idle_ready", {m_if.tvalid, s_if.tready}, 2'b01);

    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1); // constant border
    run_frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1); // edge replicate
    run_frame(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1); // junk before SOF
    run_frame(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, -1); // stalls and gaps
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1); // framing errors
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20); // reset mid-frame
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1); // fresh frame after reset

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
